// File: rtl/count_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
// Mode encodings and the prescaler phase-width helper live here so every file agrees on them.
package count_pkg;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   // A prescale of 1 still needs one phase bit so the register is never zero-width.
   function automatic int prescale_width(input int prescale);
      return (prescale <= 1) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/count_prescale.sv
// Prescaler phase counter: emits a one-cycle step on every PRESCALE-th enabled cycle.
// A restart (clear or load at the top level) returns the phase to zero and suppresses the step.
module count_prescale
   import count_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic step
);

   localparam int PW = prescale_width(PRESCALE);
   localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("count_prescale: PRESCALE must be >= 1");
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase <= '0;
      end else if (restart) begin
         phase <= '0;
      end else if (en) begin
         phase <= (phase == LAST_PHASE) ? '0 : phase + PW'(1);
      end
   end

   assign step = en && !restart && (phase == LAST_PHASE);

endmodule

// File: rtl/count_mod_updown.sv
// Modulo-N up/down counter with clear, load, count enable, prescaler and wrap/saturate mode.
// Terminal count is combinational; the wrap pulse and sticky overflow flag are registered.
module count_mod_updown
   import count_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(MODULUS - 1);
   localparam bit               SAT_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

   if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("count_mod_updown: need 2 <= MODULUS <= 2**WIDTH");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("count_mod_updown: PRESCALE must be >= 1");
   end
   if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
      $error("count_mod_updown: SATURATE must be 0 or 1");
   end

   logic             step;
   logic             restart;
   logic [WIDTH-1:0] out_next;
   logic             wrap_next;
   logic             ovf_next;
   logic             at_end;

   assign restart = clr | load;

   count_prescale #(
      .PRESCALE(PRESCALE)
   ) u_prescale (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .restart(restart),
      .step   (step)
   );

   assign at_end = up ? (out == TOP_VAL) : (out == '0);
   assign tc     = at_end;

   // Priority clr > load > step; wrap defaults low so it can only ever be a one-cycle pulse.
   always_comb begin
      out_next  = out;
      wrap_next = 1'b0;
      ovf_next  = ovf;
      if (clr) begin
         out_next = '0;
         ovf_next = 1'b0;
      end else if (load) begin
         out_next = (load_val > TOP_VAL) ? TOP_VAL : load_val;
      end else if (step) begin
         if (!at_end) begin
            out_next = up ? out + WIDTH'(1) : out - WIDTH'(1);
         end else if (SAT_MODE == MODE_SAT) begin
            ovf_next = 1'b1;
         end else begin
            out_next  = up ? '0 : TOP_VAL;
            wrap_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out  <= '0;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         out  <= out_next;
         wrap <= wrap_next;
         ovf  <= ovf_next;
      end
   end

endmodule

// File: tb/tb_count_mod_updown.sv
// Directed bench for count_mod_updown: a wrap-mode, a saturate-mode and a prescaled saturate instance.
// Expected values are hand-computed per step; outputs are sampled 1 ns after each rising edge.
module tb_count_mod_updown;

   logic clk = 1'b0;
   always #50 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       w_reset, w_en, w_up, w_clr, w_load;
   logic [3:0] w_load_val, w_out;
   logic       w_tc, w_wrap, w_ovf;

   logic       s_reset, s_en, s_up, s_clr, s_load;
   logic [3:0] s_load_val, s_out;
   logic       s_tc, s_wrap, s_ovf;

   logic       p_reset, p_en, p_up, p_clr, p_load;
   logic [3:0] p_load_val, p_out;
   logic       p_tc, p_wrap, p_ovf;

   count_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(w_reset), .en(w_en), .up(w_up), .clr(w_clr), .load(w_load),
      .load_val(w_load_val), .out(w_out), .tc(w_tc), .wrap(w_wrap), .ovf(w_ovf)
   );

   count_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_sat (
      .clk(clk), .reset(s_reset), .en(s_en), .up(s_up), .clr(s_clr), .load(s_load),
      .load_val(s_load_val), .out(s_out), .tc(s_tc), .wrap(s_wrap), .ovf(s_ovf)
   );

   count_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1)) u_pre (
      .clk(clk), .reset(p_reset), .en(p_en), .up(p_up), .clr(p_clr), .load(p_load),
      .load_val(p_load_val), .out(p_out), .tc(p_tc), .wrap(p_wrap), .ovf(p_ovf)
   );

   // Advance n rising edges and settle just past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      w_reset = 1'b0; w_en = 1'b0; w_up = 1'b1; w_clr = 1'b0; w_load = 1'b0; w_load_val = 4'd0;
      s_reset = 1'b0; s_en = 1'b0; s_up = 1'b1; s_clr = 1'b0; s_load = 1'b0; s_load_val = 4'd0;
      p_reset = 1'b0; p_en = 1'b0; p_up = 1'b1; p_clr = 1'b0; p_load = 1'b0; p_load_val = 4'd0;

      $display("[TB] reset phase");
      applyStimulus(2);
      checkOutput("reset_w_out", w_out, 0);
      checkOutput("reset_w_wrap", w_wrap, 0);
      checkOutput("reset_w_ovf", w_ovf, 0);
      checkOutput("reset_w_tc", w_tc, 0);
      checkOutput("reset_s_out", s_out, 0);
      checkOutput("reset_p_out", p_out, 0);

      $display("[TB] wrap-mode count up");
      w_reset = 1'b1; w_en = 1'b1; w_up = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1);
         checkOutput($sformatf("up_out_%0d", i), w_out, 8'(i % 10));
         checkOutput($sformatf("up_tc_%0d", i), w_tc, (i % 10 == 9) ? 8'd1 : 8'd0);
         checkOutput($sformatf("up_wrap_%0d", i), w_wrap, (i == 10) ? 8'd1 : 8'd0);
      end

      $display("[TB] wrap-mode count down");
      w_en = 1'b0; w_up = 1'b0; w_clr = 1'b1;
      applyStimulus(1);
      w_clr = 1'b0;
      #1;
      checkOutput("clr_out", w_out, 0);
      checkOutput("down_tc_at0", w_tc, 1);
      w_en = 1'b1;
      applyStimulus(1);
      checkOutput("down_out_9", w_out, 9);
      checkOutput("down_wrap_9", w_wrap, 1);
      checkOutput("down_tc_9", w_tc, 0);
      applyStimulus(1);
      checkOutput("down_out_8", w_out, 8);
      checkOutput("down_wrap_8", w_wrap, 0);
      applyStimulus(1);
      checkOutput("down_out_7", w_out, 7);
      checkOutput("down_wrap_7", w_wrap, 0);

      $display("[TB] load and clear priority");
      w_up = 1'b1; w_load = 1'b1; w_load_val = 4'd7;
      applyStimulus(1);
      checkOutput("load_7", w_out, 7);
      w_load_val = 4'd12;
      applyStimulus(1);
      checkOutput("load_clamp", w_out, 9);
      checkOutput("load_clamp_wrap", w_wrap, 0);
      w_clr = 1'b1; w_load_val = 4'd5;
      applyStimulus(1);
      checkOutput("clr_over_load", w_out, 0);
      w_clr = 1'b0; w_load = 1'b0;
      applyStimulus(1);
      checkOutput("step_after_load", w_out, 1);
      w_en = 1'b0;

      $display("[TB] saturate mode");
      s_reset = 1'b1; s_load = 1'b1; s_load_val = 4'd8;
      applyStimulus(1);
      checkOutput("sat_load_8", s_out, 8);
      s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
      applyStimulus(1);
      checkOutput("sat_out_1", s_out, 9);
      checkOutput("sat_ovf_1", s_ovf, 0);
      applyStimulus(1);
      checkOutput("sat_out_2", s_out, 9);
      checkOutput("sat_ovf_2", s_ovf, 1);
      checkOutput("sat_wrap_2", s_wrap, 0);
      applyStimulus(1);
      checkOutput("sat_out_3", s_out, 9);
      checkOutput("sat_ovf_3", s_ovf, 1);
      checkOutput("sat_wrap_3", s_wrap, 0);
      s_en = 1'b0;
      applyStimulus(1);
      checkOutput("sat_ovf_sticky", s_ovf, 1);
      s_clr = 1'b1;
      applyStimulus(1);
      checkOutput("sat_clr_out", s_out, 0);
      checkOutput("sat_clr_ovf", s_ovf, 0);
      s_clr = 1'b0; s_en = 1'b1; s_up = 1'b0;
      applyStimulus(1);
      checkOutput("sat_down_out", s_out, 0);
      checkOutput("sat_down_ovf", s_ovf, 1);
      checkOutput("sat_down_wrap", s_wrap, 0);
      s_en = 1'b0;

      $display("[TB] prescaler");
      p_reset = 1'b1; p_en = 1'b1; p_up = 1'b1;
      applyStimulus(2);
      checkOutput("pre_hold_2", p_out, 0);
      applyStimulus(1);
      checkOutput("pre_step_1", p_out, 1);
      applyStimulus(1);
      checkOutput("pre_phase1", p_out, 1);
      p_en = 1'b0;
      applyStimulus(2);
      checkOutput("pre_en_low", p_out, 1);
      p_en = 1'b1;
      applyStimulus(1);
      checkOutput("pre_resume_a", p_out, 1);
      applyStimulus(1);
      checkOutput("pre_resume_step", p_out, 2);

      $display("[TB] reset mid-count");
      p_load = 1'b1; p_load_val = 4'd0;
      applyStimulus(1);
      p_load = 1'b0; p_up = 1'b0;
      applyStimulus(3);
      checkOutput("pre_sat_out", p_out, 0);
      checkOutput("pre_sat_ovf", p_ovf, 1);
      p_load = 1'b1; p_load_val = 4'd4;
      applyStimulus(1);
      checkOutput("pre_load_keeps_ovf", p_ovf, 1);
      p_load = 1'b0; p_up = 1'b1;
      applyStimulus(3);
      checkOutput("pre_out_5", p_out, 5);
      applyStimulus(1);
      checkOutput("pre_out_5_phase1", p_out, 5);
      p_reset = 1'b0;
      applyStimulus(1);
      checkOutput("midreset_out", p_out, 0);
      checkOutput("midreset_wrap", p_wrap, 0);
      checkOutput("midreset_ovf", p_ovf, 0);
      p_reset = 1'b1;
      applyStimulus(2);
      checkOutput("postreset_hold", p_out, 0);
      applyStimulus(1);
      checkOutput("postreset_step", p_out, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
